// File: rtl/vga_scanout_fifo.sv
// FWFT pixel FIFO feeding a 640x480@60 RGB565 scanout.
// Optional underflow counter: define VGA_UNDERFLOW_CNT_EN.
module vga_scanout_fifo #(
  parameter int DEPTH   = 512,
  parameter int PREFILL = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fifo_wr_en,
  input  logic [31:0] fifo_data,
  output logic        fifo_full,
  output logic        sink_ready,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        vga_clk
`ifdef VGA_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] underflow_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    WAIT_FILL,
    RUN
  } state_e;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          fifo_full_q;
  logic          push;
  logic          pop;
  logic [31:0]   head;

  logic          pix_en_q;
  logic          vga_clk_q;
  logic          rdy1_q;
  logic          rdy_q;
  logic [9:0]    h_q;
  logic [9:0]    v_q;
  logic          h_last;
  logic          v_last;
  logic          active;

  state_e        state_q;
  state_e        state_d;
  logic          run;
  logic          pair_ok_q;
  logic          pair_ok_d;
  logic          uf_inc;
  logic [15:0]   pix_d;

  logic [23:0]   rgb_q;
  logic          hs_q;
  logic          vs_q;
  logic          blank_n_q;

  assign head = mem_q[rd_ptr_q];
  assign push = fifo_wr_en && (level_q != LW'(DEPTH));

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= fifo_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      fifo_full_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q     <= level_d;
      fifo_full_q <= (level_d >= LW'(DEPTH - 2));
    end
  end

  assign h_last = (h_q == 10'd799);
  assign v_last = (v_q == 10'd524);
  assign active = (h_q < 10'd640) && (v_q < 10'd480);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_en_q  <= 1'b1;
      vga_clk_q <= 1'b0;
      rdy1_q    <= 1'b0;
      rdy_q     <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
    end else begin
      pix_en_q  <= ~pix_en_q;
      vga_clk_q <= ~pix_en_q;
      rdy1_q    <= 1'b1;
      rdy_q     <= rdy1_q;
      if (pix_en_q) begin
        h_q <= h_last ? 10'd0 : h_q + 10'd1;
        if (h_last) begin
          v_q <= v_last ? 10'd0 : v_q + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == WAIT_FILL && pix_en_q &&
        h_q == 10'd0 && v_q == 10'd0 &&
        level_q >= LW'(PREFILL)) begin
      state_d = RUN;
    end
  end

  // The start pixel (0,0) is already served on the transition edge.
  assign run = (state_d == RUN);

  always_comb begin
    pop       = 1'b0;
    uf_inc    = 1'b0;
    pair_ok_d = pair_ok_q;
    pix_d     = 16'h0000;
    if (pix_en_q && active && run) begin
      if (!h_q[0]) begin
        if (level_q != '0) begin
          pair_ok_d = 1'b1;
          pix_d     = head[15:0];
        end else begin
          pair_ok_d = 1'b0;
          uf_inc    = 1'b1;
        end
      end else if (pair_ok_q) begin
        pix_d = head[31:16];
        pop   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_ok_q <= 1'b0;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else if (pix_en_q) begin
      pair_ok_q <= pair_ok_d;
      rgb_q     <= {pix_d[15:11], pix_d[15:13],
                    pix_d[10:5],  pix_d[10:9],
                    pix_d[4:0],   pix_d[4:2]};
      hs_q      <= !(h_q >= 10'd656 && h_q <= 10'd751);
      vs_q      <= !(v_q >= 10'd490 && v_q <= 10'd491);
      blank_n_q <= active;
    end
  end

`ifdef VGA_UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uf_cnt_q <= '0;
    end else if (uf_inc && uf_cnt_q != 16'hFFFF) begin
      uf_cnt_q <= uf_cnt_q + 16'd1;
    end
  end

  assign underflow_count = uf_cnt_q;
`else
  logic unused_uf;
  assign unused_uf = uf_inc;
`endif

  assign fifo_full   = fifo_full_q;
  assign sink_ready  = rdy_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = vga_clk_q;

endmodule

// File: tb/tb_vga_scanout_fifo.sv
// Scoreboard bench: dut_a stays in WAIT_FILL (sync, full flag),
// dut_b (PREFILL=0) runs from the first frame (data, underflow).
module tb_vga_scanout_fifo;

  logic        clk;
  logic        reset;
  logic        a_wr;
  logic [31:0] a_data;
  logic        b_wr;
  logic [31:0] b_data;

  logic        a_full, a_rdy, a_hs, a_vs, a_blank, a_sync, a_vclk;
  logic [7:0]  a_r, a_g, a_b;
  logic        b_full, b_rdy, b_hs, b_vs, b_blank, b_sync, b_vclk;
  logic [7:0]  b_r, b_g, b_b;
`ifdef VGA_UNDERFLOW_CNT_EN
  logic [15:0] a_uf, b_uf;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] words [4] = '{32'hF800_07E0, 32'h001F_FFFF,
                             32'h8410_4208, 32'h5555_AAAA};
  logic [23:0] ev [4] = '{24'h00FF00, 24'hFFFFFF,
                          24'h424142, 24'hAD5552};
  logic [23:0] od [4] = '{24'hFF0000, 24'h0000FF,
                          24'h848284, 24'h52AAAD};

  logic [23:0] sb_q [$];

  vga_scanout_fifo #(.DEPTH(512), .PREFILL(256)) dut_a (
    .clk(clk), .reset(reset),
    .fifo_wr_en(a_wr), .fifo_data(a_data),
    .fifo_full(a_full), .sink_ready(a_rdy),
    .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
    .vga_hs(a_hs), .vga_vs(a_vs),
    .vga_blank_n(a_blank), .vga_sync_n(a_sync),
    .vga_clk(a_vclk)
`ifdef VGA_UNDERFLOW_CNT_EN
    , .underflow_count(a_uf)
`endif
  );

  vga_scanout_fifo #(.DEPTH(512), .PREFILL(0)) dut_b (
    .clk(clk), .reset(reset),
    .fifo_wr_en(b_wr), .fifo_data(b_data),
    .fifo_full(b_full), .sink_ready(b_rdy),
    .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
    .vga_hs(b_hs), .vga_vs(b_vs),
    .vga_blank_n(b_blank), .vga_sync_n(b_sync),
    .vga_clk(b_vclk)
`ifdef VGA_UNDERFLOW_CNT_EN
    , .underflow_count(b_uf)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic goto_neg(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push_line(input int n, input int s);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(ev[(s + i) % 4]);
      sb_q.push_back(od[(s + i) % 4]);
    end
    for (int i = 2 * n; i < 640; i++) sb_q.push_back(24'h0);
  endtask

  task automatic b_burst(input int first, input int n, input int s);
    goto_neg(first - 1);
    for (int i = 0; i < n; i++) begin
      b_wr   = 1'b1;
      b_data = words[(s + i) % 4];
      @(negedge clk);
    end
    b_wr = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out_a"},
          64'({a_r, a_g, a_b, a_hs, a_vs, a_blank,
               a_vclk, a_full, a_rdy, a_sync}),
          64'({24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    check({tag, "_out_b"},
          64'({b_r, b_g, b_b, b_hs, b_vs, b_blank,
               b_vclk, b_full, b_rdy, b_sync}),
          64'({24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    check({tag, "_lvl_a"}, 64'(dut_a.level_q), 64'd0);
    check({tag, "_lvl_b"}, 64'(dut_b.level_q), 64'd0);
    check({tag, "_hv_a"}, 64'({dut_a.h_q, dut_a.v_q}), 64'd0);
`ifdef VGA_UNDERFLOW_CNT_EN
    check({tag, "_uf_b"}, 64'(b_uf), 64'd0);
`endif
  endtask

  // Monitor: one sample per pixel, in the half where vga_clk is low.
  always @(negedge clk) begin : mon
    int p, h, ln;
    logic ex_act, ex_hs, ex_vs;
    logic [23:0] ex_rgb;
    if (!reset && cyc >= 1 && a_vclk == 1'b0) begin
      p      = (cyc - 1) / 2;
      h      = p % 800;
      ln     = p / 800;
      ex_act = (h < 640) && (ln < 480);
      ex_hs  = !(h >= 656 && h <= 751);
      ex_vs  = !(ln >= 490 && ln <= 491);
      check("pix_a", 64'({a_r, a_g, a_b, a_hs, a_vs, a_blank}),
            64'({24'h0, ex_hs, ex_vs, ex_act}));
      ex_rgb = 24'h0;
      if (ex_act && sb_q.size() > 0) ex_rgb = sb_q.pop_front();
      check("pix_b", 64'({b_r, b_g, b_b, b_hs, b_vs, b_blank}),
            64'({ex_rgb, ex_hs, ex_vs, ex_act}));
    end
  end

  // dut_a: fill to the almost-full threshold, then overfill.
  initial begin
    a_wr   = 1'b0;
    a_data = '0;
    goto_neg(9);
    for (int i = 0; i < 510; i++) begin
      a_wr   = 1'b1;
      a_data = words[i % 4];
      @(negedge clk);
      if (i == 508) check("full_509", 64'(a_full), 64'd0);
    end
    check("full_510", 64'(a_full), 64'd1);
    check("lvl_510", 64'(dut_a.level_q), 64'd510);
    for (int i = 0; i < 3; i++) begin
      a_data = 32'hDEAD_0000 + 32'(i);
      @(negedge clk);
      check("lvl_over", 64'(dut_a.level_q),
            (i == 0) ? 64'd511 : 64'd512);
    end
    a_wr = 1'b0;
    @(negedge clk);
    check("full_hold", 64'(a_full), 64'd1);
  end

  // dut_b: data, underflow, and simultaneous push/pop.
  initial begin
    b_wr   = 1'b0;
    b_data = '0;
    push_line(0, 0);
    push_line(300, 0);
    b_burst(1282, 300, 0);
    goto_neg(1600);
    check("lvl_pre_l1", 64'(dut_b.level_q), 64'd300);
    goto_neg(1641);
    check("lvl_10pops", 64'(dut_b.level_q), 64'd290);
    push_line(100, 300);
    b_burst(2882, 100, 300);
    goto_neg(2990);
    check("lvl_pre_l2", 64'(dut_b.level_q), 64'd100);
`ifdef VGA_UNDERFLOW_CNT_EN
    check("uf_l1", 64'(b_uf), 64'd340);
`endif
    goto_neg(4480);
    check("lvl_l2_empty", 64'(dut_b.level_q), 64'd0);
`ifdef VGA_UNDERFLOW_CNT_EN
    check("uf_l2", 64'(b_uf), 64'd560);
`endif
    push_line(6, 400);
    b_burst(4482, 5, 400);
    goto_neg(4801);
    check("lvl_5", 64'(dut_b.level_q), 64'd5);
    goto_neg(4802);
    b_wr   = 1'b1;
    b_data = words[405 % 4];
    @(negedge clk);
    b_wr = 1'b0;
    check("lvl_rw", 64'(dut_b.level_q), 64'd5);
    goto_neg(4830);
    check("lvl_l3_empty", 64'(dut_b.level_q), 64'd0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("por");
    reset = 1'b0;
    @(negedge clk);
    check("rdy_1st", 64'({a_rdy, b_rdy}), 64'd0);
    @(negedge clk);
    check("rdy_2nd", 64'({a_rdy, b_rdy}), 64'd3);

    goto_neg(6400);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("mid");
    reset = 1'b0;
    @(negedge clk);
    check("mid_rdy_1st", 64'({a_rdy, b_rdy}), 64'd0);
    @(negedge clk);
    check("mid_rdy_2nd", 64'({a_rdy, b_rdy}), 64'd3);

    goto_neg(1700);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
